pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 84 ++++++++
 tb/tb_pipe_stage_reg.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with stall, flush and a LIFO backup stack that
// saves and restores the stage contents across nested interrupts.
module pipe_stage_reg #(
  parameter int unsigned WIDTH           = 160,
  parameter int unsigned BACKUP_DEPTH    = 2,
  parameter bit          CLEAR_ON_BUBBLE = 1'b1
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  in_valid,
  input  logic [WIDTH-1:0]                      in_data,
  output logic                                  in_ready,
  output logic                                  out_valid,
  output logic [WIDTH-1:0]                      out_data,
  input  logic                                  out_ready,
  input  logic                                  flush,
  input  logic                                  int_save,
  input  logic                                  int_restore,
  output logic [$clog2(BACKUP_DEPTH+1)-1:0]     depth_cnt,
  output logic                                  ovf_err,
  output logic                                  unf_err
);

  localparam int unsigned DW = $clog2(BACKUP_DEPTH + 1);
  localparam int unsigned IW = (BACKUP_DEPTH > 1) ? $clog2(BACKUP_DEPTH) : 1;
  localparam logic [DW-1:0] FULL = DW'(BACKUP_DEPTH);

  logic [WIDTH:0]  stack [BACKUP_DEPTH];
  logic [IW-1:0]   push_idx;
  logic [IW-1:0]   pop_idx;
  logic            full;
  logic            empty;
  logic            ctrl;
  logic            do_push;
  logic            do_pop;

  assign full     = (depth_cnt == FULL);
  assign empty    = (depth_cnt == '0);
  assign push_idx = IW'(depth_cnt);
  assign pop_idx  = IW'(depth_cnt - DW'(1));
  assign ctrl     = flush | int_save | int_restore;
  assign in_ready = !ctrl && (!out_valid || out_ready);

  // flush outranks save, save outranks restore
  assign do_push  = !flush && int_save && !full;
  assign do_pop   = !flush && !int_save && int_restore && !empty;

  // Stack entries are only observable after a push, so they carry no reset.
  always_ff @(posedge clk) begin
    if (do_push) stack[push_idx] <= {out_valid, out_data};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      depth_cnt <= '0;
      ovf_err   <= 1'b0;
      unf_err   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (int_save) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      if (full) ovf_err <= 1'b1;
      else      depth_cnt <= depth_cnt + DW'(1);
    end else if (int_restore) begin
      if (empty) begin
        unf_err <= 1'b1;
      end else begin
        {out_valid, out_data} <= stack[pop_idx];
        depth_cnt             <= depth_cnt - DW'(1);
      end
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
      if (CLEAR_ON_BUBBLE) out_data <= '0;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed-vector bench for pipe_stage_reg: table of per-cycle stimulus with
// hand-computed next-state, plus an asynchronous reset sequence.
module tb_pipe_stage_reg;

  localparam int unsigned W  = 16;
  localparam int unsigned BD = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_ready;
  logic          flush;
  logic          int_save;
  logic          int_restore;
  logic [1:0]    depth_cnt;
  logic          ovf_err;
  logic          unf_err;

  int tests = 0;
  int fails = 0;

  pipe_stage_reg #(
    .WIDTH(W),
    .BACKUP_DEPTH(BD),
    .CLEAR_ON_BUBBLE(1'b1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_ready(out_ready),
    .flush(flush),
    .int_save(int_save),
    .int_restore(int_restore),
    .depth_cnt(depth_cnt),
    .ovf_err(ovf_err),
    .unf_err(unf_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         iv;
    logic [W-1:0] id;
    logic         ordy, fl, sv, rs;
    logic         ir;
    logic         ov;
    logic [W-1:0] od;
    logic [1:0]   d;
    logic         ovf, unf;
  } vec_t;

  vec_t vecs[23];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic ov, input logic [W-1:0] od,
                           input logic [1:0] d, input logic ovf, input logic unf);
    chk({tag, " out_valid"}, 32'(out_valid), 32'(ov));
    chk({tag, " out_data"},  32'(out_data),  32'(od));
    chk({tag, " depth_cnt"}, 32'(depth_cnt), 32'(d));
    chk({tag, " ovf_err"},   32'(ovf_err),   32'(ovf));
    chk({tag, " unf_err"},   32'(unf_err),   32'(unf));
  endtask

  task automatic drive(input logic iv, input logic [W-1:0] id, input logic ordy,
                       input logic fl, input logic sv, input logic rs);
    in_valid    = iv;
    in_data     = id;
    out_ready   = ordy;
    flush       = fl;
    int_save    = sv;
    int_restore = rs;
  endtask

  initial begin
    //          iv  id      ordy fl  sv  rs   ir  ov  od      d     ovf unf
    vecs[0]  = '{1'b1, 16'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'hA5, 2'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 16'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h00, 2'd0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 16'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h11, 2'd0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 16'h22, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h11, 2'd0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 16'h22, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h11, 2'd0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 16'h22, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h11, 2'd0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 16'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h22, 2'd0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 16'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h00, 2'd0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 16'h33, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h33, 2'd0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 16'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h00, 2'd0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 16'h44, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h44, 2'd0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 16'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h44, 2'd0, 1'b0, 1'b1};
    vecs[12] = '{1'b1, 16'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h01, 2'd0, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 16'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h00, 2'd1, 1'b0, 1'b1};
    vecs[14] = '{1'b1, 16'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h02, 2'd1, 1'b0, 1'b1};
    vecs[15] = '{1'b0, 16'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h00, 2'd2, 1'b0, 1'b1};
    vecs[16] = '{1'b1, 16'h03, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h03, 2'd2, 1'b0, 1'b1};
    vecs[17] = '{1'b0, 16'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h00, 2'd2, 1'b1, 1'b1};
    vecs[18] = '{1'b0, 16'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h02, 2'd1, 1'b1, 1'b1};
    vecs[19] = '{1'b0, 16'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h01, 2'd0, 1'b1, 1'b1};
    vecs[20] = '{1'b0, 16'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h00, 2'd1, 1'b1, 1'b1};
    vecs[21] = '{1'b0, 16'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h00, 2'd1, 1'b1, 1'b1};
    vecs[22] = '{1'b1, 16'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h55, 2'd1, 1'b1, 1'b1};

    reset_n = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    #12;
    chk_state("reset", 1'b0, '0, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      drive(vecs[i].iv, vecs[i].id, vecs[i].ordy, vecs[i].fl, vecs[i].sv, vecs[i].rs);
      #1;
      chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vecs[i].ir));
      @(posedge clk);
      #1;
      chk_state($sformatf("v%0d", i), vecs[i].ov, vecs[i].od, vecs[i].d, vecs[i].ovf, vecs[i].unf);
    end

    // Asynchronous reset between edges with a pushed entry and a live stage.
    @(negedge clk);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    reset_n = 1'b0;
    #1;
    chk_state("async_rst", 1'b0, '0, 2'd0, 1'b0, 1'b0);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    chk_state("post_rst_restore", 1'b0, '0, 2'd0, 1'b0, 1'b1);

    // Bubble after reset: stage loads, then empties with data cleared.
    @(negedge clk);
    drive(1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("bubble load", 32'(out_data), 32'h0000BEEF);
    @(negedge clk);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("bubble clear valid", 32'(out_valid), 32'd0);
    chk("bubble clear data", 32'(out_data), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
